phase_timer: RTL and testbench

Parametrised multi-phase countdown timer for the traffic-light controller. It replaces the single fixed-length second counter with several things in one block:
- a built-in clock prescaler producing the 1-second tick;
- a runtime-programmable duration table with one entry per phase;
- automatic phase sequencing with wrap-around, pause and skip.

The light FSM consumes `phase`, `last`, `pre_last` and `phase_done` instead of running its own counter.

---
 rtl/phase_timer.sv | 96 +++++++++
 tb/tb_phase_timer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/phase_timer.sv
// Multi-phase countdown timer with built-in tick prescaler, programmable
// per-phase duration table, automatic wrap-around sequencing, pause and skip.
module phase_timer #(
  parameter int pMAX_VAL    = 99,
  parameter int pNUM_PHASES = 3,
  parameter int pTICK_DIV   = 1000,
  localparam int CW = $clog2(pMAX_VAL + 1),
  localparam int PW = $clog2(pNUM_PHASES),
  localparam int DW = $clog2(pTICK_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          skip,
  input  logic          cfg_we,
  input  logic [PW-1:0] cfg_idx,
  input  logic [CW-1:0] cfg_val,
  output logic [CW-1:0] count,
  output logic [PW-1:0] phase,
  output logic          tick,
  output logic          last,
  output logic          pre_last,
  output logic          phase_done
);

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [pNUM_PHASES-1:0][CW-1:0] tbl_q, tbl_d;

  logic [PW-1:0] nxt_phase;
  logic [CW-1:0] sat_val;
  logic [CW-1:0] load_val;
  logic          bypass;

  assign sat_val   = (cfg_val > CW'(pMAX_VAL)) ? CW'(pMAX_VAL) : cfg_val;
  assign nxt_phase = (phase_q == PW'(pNUM_PHASES - 1)) ? '0 : phase_q + PW'(1);

  // A write landing on the entry being loaded this edge wins over the stored value.
  assign bypass   = cfg_we && (cfg_idx == nxt_phase);
  assign load_val = bypass ? sat_val : tbl_q[nxt_phase];

  assign tick       = en && (div_q == DW'(pTICK_DIV - 1));
  assign last       = (count_q == '0);
  assign pre_last   = (count_q == CW'(1));
  assign phase_done = tick && last && !skip;

  assign count = count_q;
  assign phase = phase_q;

  // Out-of-range indices match no entry, so such writes fall away naturally.
  always_comb begin
    tbl_d = tbl_q;
    for (int p = 0; p < pNUM_PHASES; p++) begin
      if (cfg_we && (cfg_idx == PW'(p))) tbl_d[p] = sat_val;
    end
  end

  always_comb begin
    div_d   = div_q;
    count_d = count_q;
    phase_d = phase_q;
    if (en) begin
      if (skip) begin
        div_d   = '0;
        phase_d = nxt_phase;
        count_d = load_val;
      end else begin
        div_d = (div_q == DW'(pTICK_DIV - 1)) ? '0 : div_q + DW'(1);
        if (tick) begin
          if (count_q != '0) begin
            count_d = count_q - CW'(1);
          end else begin
            phase_d = nxt_phase;
            count_d = load_val;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      count_q <= CW'(pMAX_VAL);
      phase_q <= '0;
      for (int p = 0; p < pNUM_PHASES; p++) tbl_q[p] <= CW'(pMAX_VAL);
    end else begin
      div_q   <= div_d;
      count_q <= count_d;
      phase_q <= phase_d;
      tbl_q   <= tbl_d;
    end
  end

endmodule

// File: tb/tb_phase_timer.sv
// Table-driven bench for phase_timer (MAX=9, 3 phases, DIV=4): stimulus
// segments carry hand-derived expectations that flow through a scoreboard queue.
module tb_phase_timer;

  logic       clk, rst, en, skip, cfg_we;
  logic [1:0] cfg_idx;
  logic [3:0] cfg_val;
  logic [3:0] count;
  logic [1:0] phase;
  logic       tick, last, pre_last, phase_done;

  int checks = 0;
  int errors = 0;

  phase_timer #(.pMAX_VAL(9), .pNUM_PHASES(3), .pTICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .skip(skip), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_val(cfg_val), .count(count), .phase(phase),
    .tick(tick), .last(last), .pre_last(pre_last), .phase_done(phase_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en, skip, we;
    logic [1:0] idx;
    logic [3:0] val;
    int         n;
    logic [3:0] c;
    logic [1:0] ph;
    logic       tk, lst, pl, pd;
  } vec_t;

  typedef struct {
    int         id;
    logic [3:0] c;
    logic [1:0] ph;
    logic       tk, lst, pl, pd;
  } exp_t;

  vec_t vt[24];
  exp_t sb[$];
  bit   need_neg;

  function automatic vec_t mk(logic e, logic s, logic w, logic [1:0] i, logic [3:0] v,
                              int n, logic [3:0] c, logic [1:0] ph,
                              logic tk, logic lst, logic pl, logic pd);
    vec_t r;
    r.en = e; r.skip = s; r.we = w; r.idx = i; r.val = v; r.n = n;
    r.c = c; r.ph = ph; r.tk = tk; r.lst = lst; r.pl = pl; r.pd = pd;
    return r;
  endfunction

  task automatic chk(string name, int id, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, id, act, exp);
    end
  endtask

  task automatic cmp_outputs(int id, logic [3:0] c, logic [1:0] ph,
                             logic tk, logic lst, logic pl, logic pd);
    chk("count", id, 32'(count), 32'(c));
    chk("phase", id, 32'(phase), 32'(ph));
    chk("tick", id, 32'(tick), 32'(tk));
    chk("last", id, 32'(last), 32'(lst));
    chk("pre_last", id, 32'(pre_last), 32'(pl));
    chk("phase_done", id, 32'(phase_done), 32'(pd));
  endtask

  task automatic run_seg(int id, vec_t v);
    exp_t e, g;
    if (need_neg) @(negedge clk);
    en = v.en; skip = v.skip; cfg_we = v.we; cfg_idx = v.idx; cfg_val = v.val;
    e.id = id; e.c = v.c; e.ph = v.ph; e.tk = v.tk; e.lst = v.lst; e.pl = v.pl; e.pd = v.pd;
    sb.push_back(e);
    repeat (v.n) @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard step %0d: got empty queue expected 1 entry", id);
    end else begin
      g = sb.pop_front();
      cmp_outputs(g.id, g.c, g.ph, g.tk, g.lst, g.pl, g.pd);
    end
    need_neg = (v.n != 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           en s we idx val   n    c ph tk lst pl pd
    vt[0]  = mk(1, 0, 1, 1, 2,    1,   9, 0, 0, 0, 0, 0);
    vt[1]  = mk(1, 0, 0, 0, 0,    3,   8, 0, 0, 0, 0, 0);
    vt[2]  = mk(1, 0, 0, 0, 0,   32,   0, 0, 0, 1, 0, 0);
    vt[3]  = mk(1, 0, 0, 0, 0,    4,   2, 1, 0, 0, 0, 0);
    vt[4]  = mk(1, 0, 0, 0, 0,    4,   1, 1, 0, 0, 1, 0);
    vt[5]  = mk(1, 0, 0, 0, 0,    4,   0, 1, 0, 1, 0, 0);
    vt[6]  = mk(1, 0, 0, 0, 0,    4,   9, 2, 0, 0, 0, 0);
    vt[7]  = mk(1, 0, 0, 0, 0,   18,   5, 2, 0, 0, 0, 0);
    vt[8]  = mk(0, 0, 0, 0, 0,    7,   5, 2, 0, 0, 0, 0);
    vt[9]  = mk(1, 0, 0, 0, 0,    1,   5, 2, 1, 0, 0, 0);
    vt[10] = mk(1, 0, 0, 0, 0,    1,   4, 2, 0, 0, 0, 0);
    vt[11] = mk(1, 1, 0, 0, 0,    1,   9, 0, 0, 0, 0, 0);
    vt[12] = mk(1, 0, 0, 0, 0,   39,   0, 0, 1, 1, 0, 1);
    vt[13] = mk(1, 1, 0, 0, 0,    0,   0, 0, 1, 1, 0, 0);
    vt[14] = mk(1, 1, 0, 0, 0,    1,   2, 1, 0, 0, 0, 0);
    vt[15] = mk(1, 0, 1, 2, 0,    1,   2, 1, 0, 0, 0, 0);
    vt[16] = mk(1, 0, 1, 3, 5,    1,   2, 1, 0, 0, 0, 0);
    vt[17] = mk(1, 0, 0, 0, 0,   10,   0, 2, 0, 1, 0, 0);
    vt[18] = mk(1, 0, 0, 0, 0,    4,   9, 0, 0, 0, 0, 0);
    vt[19] = mk(1, 0, 0, 0, 0,   39,   0, 0, 1, 1, 0, 1);
    vt[20] = mk(1, 0, 1, 1, 4,    1,   4, 1, 0, 0, 0, 0);
    vt[21] = mk(1, 0, 1, 2, 15,   1,   4, 1, 0, 0, 0, 0);
    vt[22] = mk(1, 0, 0, 0, 0,   19,   9, 2, 0, 0, 0, 0);
    vt[23] = mk(1, 0, 0, 0, 0,   84,   3, 1, 0, 0, 0, 0);

    rst = 1'b1; en = 1'b1; skip = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_val = '0;
    #12;
    cmp_outputs(100, 4'd9, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    need_neg = 1'b0;
    for (int i = 0; i < 24; i++) run_seg(i, vt[i]);

    // Async reset mid-cycle in phase 1 with count 3 and a pending write.
    #2;
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_val = 4'd2;
    rst = 1'b1;
    #1;
    cmp_outputs(200, 4'd9, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    cmp_outputs(201, 4'd9, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    cfg_we = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("tick", 202, 32'(tick), 32'd0);
    @(posedge clk);
    #1;
    chk("tick", 203, 32'(tick), 32'd1);
    chk("count", 203, 32'(count), 32'd9);
    @(posedge clk);
    #1;
    chk("count", 204, 32'(count), 32'd8);
    chk("tick", 204, 32'(tick), 32'd0);
    repeat (36) @(posedge clk);
    #1;
    chk("phase", 205, 32'(phase), 32'd1);
    chk("count", 205, 32'(count), 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
